// File: rtl/ccgrcg_resp_misr.sv
// Exhaustive pattern driver and MISR response compactor for CCGRCG netlists.
// Walks all 2^IN_W input patterns, folds responses, compares against golden.
module ccgrcg_resp_misr #(
  parameter int               IN_W  = 6,
  parameter int               OUT_W = 19,
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF,
  parameter int               LAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [OUT_W-1:0] resp_i,
  input  logic [SIG_W-1:0] expected_i,
  output logic [IN_W-1:0]  pat_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [SIG_W-1:0] sig_o,
  output logic             pass_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int PW = (LAT > 0) ? LAT : 1;
  localparam logic [IN_W:0] LAST = {1'b0, {IN_W{1'b1}}};

  state_t           r_state;
  state_t           w_next;
  logic [IN_W:0]    r_cnt;
  logic [1:0]       r_dcnt;
  logic [PW-1:0]    r_vpipe;
  logic [PW-1:0]    w_vnext;
  logic [IN_W-1:0]  r_pat;
  logic [SIG_W-1:0] r_sig;
  logic             r_pass;
  logic             w_tok;
  logic             w_cap;
  logic             w_last;
  logic             w_drained;
  logic             w_start;
  logic [SIG_W-1:0] w_misr;

  assign w_tok     = (r_state == S_RUN);
  assign w_last    = (r_cnt == LAST);
  assign w_drained = (r_dcnt == 2'(LAT - 1));
  assign w_start   = (r_state == S_IDLE) && start_i;

  // Token pipe mirrors the netlist latency so capture lines up with responses
  if (PW == 1) begin : g_p1
    assign w_vnext = w_tok;
  end else begin : g_pn
    assign w_vnext = {r_vpipe[PW-2:0], w_tok};
  end

  assign w_cap  = (LAT == 0) ? w_tok : r_vpipe[PW-1];
  assign w_misr = {r_sig[SIG_W-2:0], 1'b0}
                ^ (r_sig[SIG_W-1] ? POLY : '0)
                ^ SIG_W'(resp_i);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start_i) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = (LAT == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (w_drained) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_vpipe <= '0;
      r_pat   <= '0;
      r_sig   <= SEED;
      r_pass  <= 1'b0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_vpipe <= '0;
      r_pat   <= '0;
      r_sig   <= SEED;
      r_pass  <= 1'b0;
    end else begin
      r_vpipe <= w_vnext;
      if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 1'b1;
        if (!w_last) r_pat <= r_cnt[IN_W-1:0] + 1'b1;
      end
      if (r_state == S_DRAIN) r_dcnt <= r_dcnt + 1'b1;
      if (w_cap) r_sig <= w_misr;
      if (r_state == S_DONE) r_pass <= (r_sig == expected_i);
    end
  end

  assign pat_o  = r_pat;
  assign busy_o = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_o = (r_state == S_DONE);
  assign sig_o  = r_sig;
  // Verdict is visible in the completion cycle itself, then held
  assign pass_o = (r_state == S_DONE) ? (r_sig == expected_i) : r_pass;

endmodule

// File: tb/tb_ccgrcg_resp_misr.sv
// Bench for ccgrcg_resp_misr: LAT=0 and LAT=2 instances at SEED=0 plus a
// default-parameter instance, all checked against a whole-run MISR model.
module tb_ccgrcg_resp_misr;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [18:0] tbl [64];
  logic [31:0] exp0, exp2, expd;

  logic [5:0]  pat0, pat2, patd, d1, d2;
  logic [18:0] resp0, resp2, respd;
  logic        busy0, busy2, busyd;
  logic        done0, done2, doned;
  logic        pass0, pass2, passd;
  logic [31:0] sig0, sig2, sigd;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= pat2;
    d2 <= d1;
  end

  assign resp0 = tbl[pat0];
  assign resp2 = tbl[d2];
  assign respd = tbl[patd];

  ccgrcg_resp_misr #(.SEED(32'h0), .LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .resp_i(resp0),
    .expected_i(exp0), .pat_o(pat0), .busy_o(busy0), .done_o(done0),
    .sig_o(sig0), .pass_o(pass0));

  ccgrcg_resp_misr #(.SEED(32'h0), .LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .resp_i(resp2),
    .expected_i(exp2), .pat_o(pat2), .busy_o(busy2), .done_o(done2),
    .sig_o(sig2), .pass_o(pass2));

  ccgrcg_resp_misr ud (
    .clk(clk), .rst_n(rst_n), .start_i(start), .resp_i(respd),
    .expected_i(expd), .pat_o(patd), .busy_o(busyd), .done_o(doned),
    .sig_o(sigd), .pass_o(passd));

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference signature: fold the whole response table in pattern order
  function automatic logic [31:0] model(input logic [31:0] seed);
    logic [31:0] s;
    s = seed;
    for (int k = 0; k < 64; k++) begin
      s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ {13'h0, tbl[k]};
    end
    return s;
  endfunction

  task automatic fill(input int mode);
    for (int k = 0; k < 64; k++) begin
      if (mode == 0)      tbl[k] = '0;
      else if (mode < 0)  tbl[k] = (k == -mode) ? 19'h1 : 19'h0;
      else                tbl[k] = 19'($urandom);
    end
  endtask

  task automatic run(input string tag, input int bstart_k,
                     input logic [31:0] m0, input logic [31:0] md);
    int perr = 0;
    int nd0 = 0;
    int dc0 = -1;
    int dc2 = -1;
    int b0f = -1, b0l = -1, b2f = -1, b2l = -1;
    logic p0d = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      @(posedge clk);
      #1 start = (bstart_k >= 0) && (c == bstart_k + 1);
      @(negedge clk);
      if (c <= 64 && pat0 != 6'(c - 1)) perr++;
      if (c > 64 && pat0 != 6'h3f) perr++;
      if (done0) begin
        nd0++;
        dc0 = c;
        p0d = pass0;
      end
      if (done2) dc2 = c;
      if (busy0) begin
        if (b0f < 0) b0f = c;
        b0l = c;
      end
      if (busy2) begin
        if (b2f < 0) b2f = c;
        b2l = c;
      end
    end
    chk({tag, "_patseq"}, perr, 0);
    chk({tag, "_done0_cyc"}, dc0, 65);
    chk({tag, "_done0_cnt"}, nd0, 1);
    chk({tag, "_busy0"}, {b0f, b0l}, {32'd1, 32'd64});
    chk({tag, "_busy2"}, {b2f, b2l}, {32'd1, 32'd66});
    chk({tag, "_done2_cyc"}, dc2, 67);
    chk({tag, "_sig0"}, sig0, m0);
    chk({tag, "_sig2"}, sig2, m0);
    chk({tag, "_sigd"}, sigd, md);
    chk({tag, "_pass0_at_done"}, p0d, m0 == exp0);
    chk({tag, "_pass0"}, pass0, m0 == exp0);
    chk({tag, "_pass2"}, pass2, m0 == exp2);
    chk({tag, "_passd"}, passd, md == expd);
  endtask

  task automatic rand_run(input string tag, input int bstart_k);
    logic [31:0] m0, md;
    fill(1);
    m0   = model(32'h0);
    md   = model(32'hFFFFFFFF);
    exp0 = m0;
    exp2 = m0 ^ 32'h1;
    expd = md;
    run(tag, bstart_k, m0, md);
  endtask

  initial begin
    logic [31:0] m0, md;
    bit found;
    rst_n = 1'b0;
    start = 1'b1;
    exp0  = '0;
    exp2  = '0;
    expd  = '0;
    fill(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pat", pat0, 6'h0);
    chk("rst_busy", {busy0, busy2, busyd}, 3'b000);
    chk("rst_done", {done0, done2, doned}, 3'b000);
    chk("rst_pass", {pass0, pass2, passd}, 3'b000);
    chk("rst_sigd", sigd, 32'hFFFFFFFF);
    chk("rst_sig0", sig0, 32'h0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_norun", busyd, 1'b0);

    fill(0);
    md = model(32'hFFFFFFFF);
    expd = md;
    run("zero", -1, 32'h0, md);
    chk("zero_sig0_const", sig0, 32'h0);

    fill(-63);
    md = model(32'hFFFFFFFF);
    run("bit63", -1, model(32'h0), md);
    chk("bit63_sig_const", sig0, 32'h00000001);

    fill(-62);
    md = model(32'hFFFFFFFF);
    run("bit62", -1, model(32'h0), md);
    chk("bit62_sig_const", sig0, 32'h00000002);

    rand_run("rnd_a", -1);
    rand_run("rnd_b", -1);
    rand_run("busy_start", 20);

    fill(1);
    m0 = model(32'h0);
    md = model(32'hFFFFFFFF);
    exp0 = m0;
    exp2 = m0;
    expd = md;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (pat0 == 6'd20) found = 1'b1;
    end
    chk("mr_found", found, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_pat", pat0, 6'h0);
    chk("mr_busy", {busy0, busy2, busyd}, 3'b000);
    chk("mr_done", {done0, done2, doned}, 3'b000);
    chk("mr_pass", {pass0, pass2, passd}, 3'b000);
    chk("mr_sig", {sig0, sigd}, {32'h0, 32'hFFFFFFFF});
    rst_n = 1'b1;
    run("after_rst", -1, m0, md);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
